// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
// Time-multiplexed driver for a row of common-anode seven-segment digits.
// A prescaler divides clk into per-digit slots of DIV cycles; the digit index
// walks 0..DIGITS-1 and each full pass is one frame. New data is staged on
// load and only committed to the visible display at a frame boundary, so a
// frame never shows a mix of old and new digits.
//
// Ports
//   clk        : system clock, rising-edge active
//   rst_n      : asynchronous active-low reset
//   load       : one-cycle strobe, captures data_in/dp_in into staging
//   data_in    : 4*DIGITS hex nibbles, nibble i = bits [4i+3:4i], digit 0 rightmost
//   dp_in      : per-digit decimal point request, 1 = lit
//   en_mask    : per-digit enable, 0 = digit dark (sampled live)
//   lz_blank   : 1 = leading-zero blanking on (sampled live)
//   AN         : registered anode selects, active-low
//   SEG_C      : registered segments, active-low, [6:0] = g..a, [7] = dp
//   frame_done : one-cycle pulse in the cycle after each frame wrap
//   pending    : staged data waiting to be committed at the next wrap
module seg7_scan_ctrl #(
  parameter int DIGITS = 8,
  parameter int DIV    = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     en_mask,
  input  logic                  lz_blank,
  output logic [DIGITS-1:0]     AN,
  output logic [7:0]            SEG_C,
  output logic                  frame_done,
  output logic                  pending
);

  localparam int CNTW = $clog2(DIV);
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int STW  = 5 * DIGITS;

  // Staging/display words are packed as {nibbles, dp bits}.
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [STW-1:0]    stage_q, stage_d;
  logic [STW-1:0]    disp_q, disp_d;
  logic              pend_q, pend_d;
  logic              fdone_q, fdone_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [7:0]        seg_q, seg_d;

  logic tick;
  logic lastIdx;
  logic wrap;

  logic [4*DIGITS-1:0] dispData;
  logic [DIGITS-1:0]   dispDp;
  logic [3:0]          nib;
  logic                dpSel;
  logic                enSel;
  logic                upperZero;
  logic                blank;
  logic                dark;
  logic [DIGITS-1:0]   anSel;
  logic [6:0]          segCode;

  assign tick     = (cnt_q == CNTW'(DIV - 1));
  assign lastIdx  = (idx_q == IDXW'(DIGITS - 1));
  assign wrap     = tick && lastIdx;
  assign dispData = disp_q[STW-1:DIGITS];
  assign dispDp   = disp_q[DIGITS-1:0];

  // Scan timing and the staging/commit handshake. Dark digits never alter
  // the slot length, so the frame period is always DIGITS*DIV cycles.
  always_comb begin
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    stage_d = stage_q;
    disp_d  = disp_q;
    pend_d  = pend_q;
    fdone_d = wrap;

    if (tick) begin
      idx_d = lastIdx ? '0 : idx_q + 1'b1;
    end

    // Commit uses the staging value from before this cycle's load, so a load
    // landing on the wrap edge is kept pending for the following frame.
    if (wrap && pend_q) begin
      disp_d = stage_q;
      pend_d = 1'b0;
    end

    if (load) begin
      stage_d = {data_in, dp_in};
      pend_d  = 1'b1;
    end
  end

  // Select the current digit, apply mask and leading-zero blanking, decode.
  always_comb begin
    nib       = 4'h0;
    dpSel     = 1'b0;
    enSel     = 1'b0;
    upperZero = 1'b1;
    anSel     = '1;

    for (int j = 0; j < DIGITS; j++) begin
      if (IDXW'(j) == idx_q) begin
        nib      = dispData[4*j +: 4];
        dpSel    = dispDp[j];
        enSel    = en_mask[j];
        anSel[j] = 1'b0;
      end
      // A digit is a leading zero only if it and every digit left of it is zero.
      if ((IDXW'(j) >= idx_q) && (dispData[4*j +: 4] != 4'h0)) begin
        upperZero = 1'b0;
      end
    end

    blank = lz_blank && (idx_q != '0) && upperZero && !dpSel;
    dark  = !enSel || blank;

    case (nib)
      4'h0: segCode = 7'h40;
      4'h1: segCode = 7'h79;
      4'h2: segCode = 7'h24;
      4'h3: segCode = 7'h30;
      4'h4: segCode = 7'h19;
      4'h5: segCode = 7'h12;
      4'h6: segCode = 7'h02;
      4'h7: segCode = 7'h78;
      4'h8: segCode = 7'h00;
      4'h9: segCode = 7'h10;
      4'hA: segCode = 7'h08;
      4'hB: segCode = 7'h03;
      4'hC: segCode = 7'h46;
      4'hD: segCode = 7'h21;
      4'hE: segCode = 7'h06;
      default: segCode = 7'h0E;
    endcase

    an_d  = dark ? '1 : anSel;
    seg_d = dark ? 8'hFF : {~dpSel, segCode};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      disp_q  <= '0;
      pend_q  <= 1'b0;
      fdone_q <= 1'b0;
      an_q    <= '1;
      seg_q   <= 8'hFF;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      fdone_q <= fdone_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign AN         = an_q;
  assign SEG_C      = seg_q;
  assign frame_done = fdone_q;
  assign pending    = pend_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl
// Directed bench for seg7_scan_ctrl with DIGITS=4, DIV=4 (16-cycle frame).
// A table of load/mask/blanking records with hand-decoded per-digit segment
// values is replayed frame by frame; hand-written sequences cover reset,
// frame period, load on the wrap edge and asynchronous reset with data staged.
module tb_seg7_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;

  logic        clk = 1'b0;
  logic        rstN;
  logic        load;
  logic [15:0] dataIn;
  logic [3:0]  dpIn;
  logic [3:0]  enMask;
  logic        lzBlank;
  logic [3:0]  an;
  logic [7:0]  segC;
  logic        frameDone;
  logic        pending;

  int vecCount  = 0;
  int missCount = 0;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  mask;
    logic        lz;
    logic [31:0] seg;   // {digit3, digit2, digit1, digit0}
    logic [3:0]  dark;  // digits expected to be fully off
  } vec_t;

  vec_t vecs[9];

  seg7_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV)) dut (
    .clk        (clk),
    .rst_n      (rstN),
    .load       (load),
    .data_in    (dataIn),
    .dp_in      (dpIn),
    .en_mask    (enMask),
    .lz_blank   (lzBlank),
    .AN         (an),
    .SEG_C      (segC),
    .frame_done (frameDone),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Waits (at negedges) until frame_done is seen; a timeout counts as a miss.
  task automatic waitFrameDone(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (frameDone === 1'b1) seen = 1'b1;
    end
    if (!seen) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dp);
    dataIn = d;
    dpIn   = dp;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  // Called on the negedge right after frame_done: checks all four digit slots.
  task automatic checkFrame(input string name, input logic [31:0] seg,
                            input logic [3:0] dark);
    logic [3:0] anExp;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      anExp = 4'hF;
      if (!dark[d]) anExp[d] = 1'b0;
      checkOutput($sformatf("%s_an%0d", name, d), {28'd0, an}, {28'd0, anExp});
      checkOutput($sformatf("%s_seg%0d", name, d), {24'd0, segC}, {24'd0, seg[8*d +: 8]});
      repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    int cycles;

    vecs[0] = '{16'h0000, 4'b0000, 4'b1111, 1'b0, 32'hC0C0C0C0, 4'b0000};
    vecs[1] = '{16'h12AF, 4'b0010, 4'b1111, 1'b0, 32'hF9A4088E, 4'b0000};
    vecs[2] = '{16'h0030, 4'b0000, 4'b1111, 1'b1, 32'hFFFFB0C0, 4'b1100};
    vecs[3] = '{16'h0030, 4'b1000, 4'b1111, 1'b1, 32'h40FFB0C0, 4'b0100};
    vecs[4] = '{16'h6789, 4'b0001, 4'b1011, 1'b0, 32'h82FF8010, 4'b0100};
    vecs[5] = '{16'hBCDE, 4'b0000, 4'b1111, 1'b1, 32'h83C6A186, 4'b0000};
    vecs[6] = '{16'h0004, 4'b0100, 4'b1111, 1'b1, 32'hFF40FF99, 4'b1010};
    vecs[7] = '{16'h5730, 4'b0000, 4'b1111, 1'b0, 32'h92F8B0C0, 4'b0000};
    vecs[8] = '{16'h0000, 4'b0000, 4'b1110, 1'b1, 32'hFFFFFFFF, 4'b1111};

    rstN    = 1'b0;
    load    = 1'b0;
    dataIn  = 16'h0;
    dpIn    = 4'h0;
    enMask  = 4'hF;
    lzBlank = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_an", {28'd0, an}, 32'hF);
    checkOutput("rst_seg", {24'd0, segC}, 32'hFF);
    checkOutput("rst_pending", {31'd0, pending}, 32'd0);
    checkOutput("rst_fdone", {31'd0, frameDone}, 32'd0);

    // First registered output after release: digit 0 showing 0
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("first_an", {28'd0, an}, 32'hE);
    checkOutput("first_seg", {24'd0, segC}, 32'hC0);

    // Frame period and pulse width
    waitFrameDone("sync0");
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cycles++;
      if (frameDone === 1'b1) break;
    end
    checkOutput("frame_period", cycles, 32'd16);
    @(negedge clk);
    checkOutput("fdone_width", {31'd0, frameDone}, 32'd0);

    // Table-driven frames: load mid-frame, commit on wrap, check next frame
    foreach (vecs[v]) begin
      enMask  = vecs[v].mask;
      lzBlank = vecs[v].lz;
      applyStimulus(vecs[v].data, vecs[v].dp);
      checkOutput($sformatf("v%0d_pend_set", v), {31'd0, pending}, 32'd1);
      waitFrameDone($sformatf("v%0d", v));
      checkOutput($sformatf("v%0d_pend_clr", v), {31'd0, pending}, 32'd0);
      checkFrame($sformatf("v%0d", v), vecs[v].seg, vecs[v].dark);
    end

    // Load landing exactly on the wrap edge
    enMask  = 4'hF;
    lzBlank = 1'b0;
    waitFrameDone("cw_sync");
    repeat (2) @(negedge clk);
    applyStimulus(16'h1111, 4'b0000);
    checkOutput("cw_pend_staged", {31'd0, pending}, 32'd1);
    checkOutput("cw_hold_before_wrap", {24'd0, segC}, 32'hC0);
    repeat (12) @(negedge clk);
    applyStimulus(16'h2222, 4'b0000);
    checkOutput("cw_wrap_fdone", {31'd0, frameDone}, 32'd1);
    checkOutput("cw_pend_kept", {31'd0, pending}, 32'd1);
    @(negedge clk);
    checkOutput("cw_first_commit", {24'd0, segC}, 32'hF9);
    waitFrameDone("cw_next");
    checkOutput("cw_pend_clr", {31'd0, pending}, 32'd0);
    @(negedge clk);
    checkOutput("cw_second_commit", {24'd0, segC}, 32'hA4);

    // Asynchronous reset mid-frame with data staged
    applyStimulus(16'h3333, 4'b1111);
    checkOutput("ar_pend_set", {31'd0, pending}, 32'd1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("ar_an", {28'd0, an}, 32'hF);
    checkOutput("ar_seg", {24'd0, segC}, 32'hFF);
    checkOutput("ar_pending", {31'd0, pending}, 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("ar_first_an", {28'd0, an}, 32'hE);
    checkOutput("ar_first_seg", {24'd0, segC}, 32'hC0);
    cycles = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cycles++;
      if (frameDone === 1'b1) break;
    end
    checkOutput("ar_first_frame", cycles, 32'd16);
    checkOutput("ar_no_commit_pend", {31'd0, pending}, 32'd0);
    @(negedge clk);
    checkOutput("ar_no_commit_seg", {24'd0, segC}, 32'hC0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
